// File: rtl/async_fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM encoding and the
// field layout of the word pushed into the FIFO ({id, last, data}).
package async_fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int DATA_LSB = 0;

  function automatic int last_bit(input int data_len);
    return data_len;
  endfunction

  function automatic int id_lsb(input int data_len);
    return data_len + 1;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arb_rr_pick.sv
// Combinational round-robin selector: returns the first asserted request
// found by searching cyclically upward from rr_ptr (modulo NUM_REQ).
module async_fifo_wr_arb_rr_pick
  import async_fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_LEN  = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_LEN-1:0]  rr_ptr,
  output logic               any,
  output logic [ID_LEN-1:0]  index
);

  logic [ID_LEN-1:0]  cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // Candidate gi is the requester sitting gi places after rr_ptr.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [ID_LEN:0] sum;
    assign sum          = {1'b0, rr_ptr} + (ID_LEN+1)'(gi);
    assign cand_idx[gi] = (sum >= (ID_LEN+1)'(NUM_REQ)) ?
                          ID_LEN'(sum - (ID_LEN+1)'(NUM_REQ)) : sum[ID_LEN-1:0];
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    any   = |req;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) index = cand_idx[k];
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among
// NUM_REQ requesters; each beat is tagged with its source id and last flag.
module async_fifo_wr_arb
  import async_fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_LEN  = 64,
  parameter int ID_LEN    = 2,
  parameter int MAX_BEATS = 16
) (
  input  logic                         clk_w,
  input  logic                         rstn_w,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         fifo_full,
  output logic                         fifo_wen,
  output logic [DATA_LEN+ID_LEN:0]     fifo_data,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CNT_W    = $clog2(MAX_BEATS + 1);
  localparam int LAST_BIT = last_bit(DATA_LEN);
  localparam int ID_LSB   = id_lsb(DATA_LEN);

  arb_state_e        state_reg, state_next;
  logic [ID_LEN-1:0] rr_ptr_reg, rr_ptr_next;
  logic [ID_LEN-1:0] gnt_id_reg, gnt_id_next, gnt_id_wrap;
  logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;
  logic              overrun_reg, overrun_next;

  logic                pick_any;
  logic [ID_LEN-1:0]   pick_idx;
  logic [DATA_LEN-1:0] req_data_arr [NUM_REQ];
  logic                gnt_valid, gnt_last, transfer, watchdog, push_last;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_data_arr[gi] = req_data[gi*DATA_LEN +: DATA_LEN];
    assign req_ready[gi]    = (state_reg == LOCK) && !fifo_full &&
                              (gnt_id_reg == ID_LEN'(gi));
  end

  async_fifo_wr_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_LEN  (ID_LEN)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .any    (pick_any),
    .index  (pick_idx)
  );

  assign gnt_valid = req_valid[gnt_id_reg];
  assign gnt_last  = req_last[gnt_id_reg];
  assign transfer  = (state_reg == LOCK) && gnt_valid && !fifo_full;
  // A runaway packet is cut at MAX_BEATS by forcing last on the final beat.
  assign watchdog  = transfer && !gnt_last &&
                     (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));
  assign push_last = gnt_last || watchdog;
  assign gnt_id_wrap = (gnt_id_reg == ID_LEN'(NUM_REQ - 1)) ?
                       '0 : gnt_id_reg + ID_LEN'(1);

  assign fifo_wen                          = transfer;
  assign fifo_data[DATA_LSB +: DATA_LEN]   = req_data_arr[gnt_id_reg];
  assign fifo_data[LAST_BIT]               = push_last;
  assign fifo_data[ID_LSB +: ID_LEN]       = gnt_id_reg;
  assign busy                              = (state_reg == LOCK);
  assign overrun                           = overrun_reg;

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    gnt_id_next   = gnt_id_reg;
    beat_cnt_next = beat_cnt_reg;
    overrun_next  = overrun_reg || watchdog;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          gnt_id_next = pick_idx;
          state_next  = LOCK;
        end
      end
      LOCK: begin
        if (transfer) begin
          if (push_last) begin
            state_next    = IDLE;
            rr_ptr_next   = gnt_id_wrap;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_w or negedge rstn_w) begin
    if (!rstn_w) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      gnt_id_reg   <= '0;
      beat_cnt_reg <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      gnt_id_reg   <= gnt_id_next;
      beat_cnt_reg <= beat_cnt_next;
      overrun_reg  <= overrun_next;
    end
  end

endmodule

// File: doc/async_fifo_wr_arb.md
Name: async_fifo_wr_arb

Overview:
- Write-side arbiter that shares one asynchronous FIFO's write port among NUM_REQ requesters in the clk_w domain.
- Grants whole packets (beats up to and including `last`) in round-robin order, so packets from different requesters never interleave.
- Tags every beat with the source ID and a last flag, so the read-side consumer can demultiplex.
- Sits directly in front of the FIFO write port (wen/full/data_in).

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_LEN, 64, payload width per beat.
- ID_LEN, 2, source-ID width; must satisfy 2**ID_LEN ≥ NUM_REQ.
- MAX_BEATS, 16, watchdog limit of beats per packet (≥1).

Ports:
- clk_w  in  1  write-domain clock.
- rstn_w  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_LEN  packed payloads; requester i occupies bits [i*DATA_LEN +: DATA_LEN].
- req_last  in  NUM_REQ  per-requester last-beat flag.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  in  1  FIFO full flag.
- fifo_wen  out  1  FIFO write enable.
- fifo_data  out  DATA_LEN+ID_LEN+1  beat pushed to the FIFO, packed as {id, last, data}.
- busy  out  1  high while a packet is locked.
- overrun  out  1  sticky; set when the watchdog fires.

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, gnt_id=0, beat_cnt=0, overrun=0. Outputs at reset: req_ready=0, fifo_wen=0, busy=0, overrun=0.
- FSM IDLE:
  - If any req_valid is high, choose the first asserted index, searching cyclically from rr_ptr.
  - Register the choice into gnt_id and go to LOCK next cycle.
  - This costs a one-cycle arbitration bubble; no beat transfers in IDLE.
  - If no req_valid is high, stay in IDLE.
- FSM LOCK:
  - busy=1.
  - req_ready[gnt_id] = !fifo_full; all other req_ready bits are 0.
  - Transfer occurs when req_valid[gnt_id] & !fifo_full.
  - fifo_wen = transfer (combinational); fifo_data = {gnt_id, req_last[gnt_id], req_data slice of gnt_id}.
  - On a transfer: beat_cnt increments.
  - Transfer with last=1: return to IDLE, rr_ptr = gnt_id+1 (wraps to 0 at NUM_REQ), beat_cnt=0.
  - Transfer of beat number MAX_BEATS with last=0 (watchdog):
    - Set overrun, which stays set until reset.
    - Force the pushed last bit to 1.
    - Release to IDLE exactly as for a normal last beat.
- fifo_full high: no transfer and no state change; the lock is held indefinitely.
- req_valid[gnt_id] dropping mid-packet: the lock is held; the other requesters wait.
- Single requester: it is re-granted after each packet, with a 1-cycle bubble between packets.
- rr_ptr arithmetic is modulo NUM_REQ. NUM_REQ need not be a power of two.
- A reset mid-packet abandons the packet. Nothing further is pushed after reset.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, LOCK=1'b1) and the fifo_data field offsets (DATA_LSB=0, LAST_BIT=DATA_LEN, ID_LSB=DATA_LEN+1).
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: request vector, rr_ptr.
  - Outputs: any, index.
- The FSM, counter and muxing live in the top module.

Test Plan:
- Req 1 valid, 3-beat packet (data 0xA0, 0xA1, 0xA2, last on beat 3), full=0 → fifo_wen on cycles 2–4; fifo_data id=1; last=0,0,1; rr_ptr=2 afterwards.
- Req 0 and req 2 both valid with 1-beat packets, rr_ptr=0 → req 0 is granted first, then req 2. The pushed ids are 0,2 with no interleaving. rr_ptr=3 at the end.
- Hold fifo_full=1 for 5 cycles mid-packet on req 3 → req_ready=0 and fifo_wen=0 throughout. The packet resumes when full drops, with no beat lost or duplicated.
- With MAX_BEATS=16, req 0 streams 20 beats and never asserts last → beat 16 is pushed with last=1, overrun=1, and the arbiter returns to IDLE. overrun stays 1 until reset.
- Assert rstn_w low mid-packet (beat 2 of 4) → fifo_wen=0, req_ready=0, busy=0 immediately. After release the state is IDLE with rr_ptr=0.
- All 4 requesters continuously valid with 1-beat packets → grants rotate 0,1,2,3,0, with one push every 2 cycles.
